// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   - default widths for the carried fields and the stall counter
//   - state encoding of the stage controller
//   - index of the control-word field that is zeroed on bubbles
//   - helper that maps a controller state to the number of held entries
package pipe_skid_stage_pkg;

    localparam int DEF_FIELD_W    = 16;
    localparam int DEF_NUM_FIELDS = 6;
    localparam int DEF_CNT_W      = 16;

    localparam int CTRL_FIELD = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] state_occupancy(input skid_state_e s);
        logic [1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            FULL:    occ = 2'd1;
            SKID:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-low reset, clears the count
//   inc  in   add one this cycle (ignored once the count is all ones)
//   clr  in   synchronous clear, wins over inc
//   cnt  out  current count
module sat_counter
    import pipe_skid_stage_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: one main register plus a one-entry skid buffer
// between two valid/ready interfaces. in_ready depends only on registered
// state, so downstream backpressure never reaches upstream combinationally.
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage accepts this cycle (low only when both entries held)
//   in_data    in   NUM_FIELDS packed fields, field k at [k*FIELD_W +: FIELD_W]
//   out_valid  out  out_data holds a valid entry
//   out_ready  in   downstream takes out_data this cycle
//   out_data   out  packed fields to the next stage
//   flush      in   drop all held entries and the entry offered this cycle
//   cnt_clr    in   clear the stall counter
//   occupancy  out  entries held: 0, 1 or 2
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
//
// state | meaning
// EMPTY | nothing held, output is a bubble
// FULL  | one entry in main, presented on the output
// SKID  | main presented, second entry parked in skid, upstream stalled
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int FIELD_W             = DEF_FIELD_W,
    parameter int NUM_FIELDS          = DEF_NUM_FIELDS,
    parameter int CNT_W               = DEF_CNT_W,
    parameter bit ZERO_CTRL_ON_BUBBLE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
    input  logic                          flush,
    input  logic                          cnt_clr,
    output logic [1:0]                    occupancy,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int DATA_W = NUM_FIELDS * FIELD_W;

    skid_state_e       state_q;
    skid_state_e       state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              acc;
    logic              dq;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (acc) state_d = FULL;
                FULL: begin
                    if (acc && !dq)      state_d = SKID;
                    else if (!acc && dq) state_d = EMPTY;
                end
                SKID:  if (dq) state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end
    end

    // outputs and data-register load enables
    always_comb begin
        in_ready  = (state_q != SKID);
        out_valid = (state_q != EMPTY);
        occupancy = state_occupancy(state_q);
        acc       = in_valid && in_ready;
        dq        = out_valid && out_ready;

        // Loads are gated by flush so a killed entry never lands in a register.
        load_main_in   = !flush && acc &&
                         ((state_q == EMPTY) || ((state_q == FULL) && dq));
        load_main_skid = !flush && (state_q == SKID) && dq;
        load_skid      = !flush && (state_q == FULL) && acc && !dq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    // Bubbles present a NOP control word; the other fields keep stale contents.
    always_comb begin
        out_data = main_q;
        if (ZERO_CTRL_ON_BUBBLE && !out_valid) begin
            out_data[CTRL_FIELD*FIELD_W +: FIELD_W] = '0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

endmodule
